// File: rtl/mul_cell_pkg.sv
// Shared widths and bundle types for the multiplier-cell combiner.
// Build option: MUL_CELL_HIGH_WORD_EN adds the a_hi*b_hi product and the high result word.
package mul_cell_pkg;

    localparam int PP_W      = 32;
    localparam int HALF_W    = 16;
    localparam int MUL_TAG_W = 5;

    typedef struct packed {
        logic [PP_W-1:0]      p1;
        logic [PP_W-1:0]      p2;
        logic [PP_W-1:0]      p3;
`ifdef MUL_CELL_HIGH_WORD_EN
        logic [PP_W-1:0]      p4;
`endif
        logic [MUL_TAG_W-1:0] tag;
    } mul_pp_t;

    typedef struct packed {
`ifdef MUL_CELL_HIGH_WORD_EN
        logic [PP_W-1:0]      result_hi;
`endif
        logic [PP_W-1:0]      result;
        logic [MUL_TAG_W-1:0] tag;
    } mul_res_t;

endpackage

// File: rtl/mul_pipe_stage.sv
// Generic one-entry valid/ready register slice; the combiner chains two of these.
module mul_pipe_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Handshake: a word moves when valid and ready are both high at a rising
    // edge; valid never waits on ready, and ready here depends only on the
    // slice's own occupancy and the downstream ready.
    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else if (in_ready) begin
            valid_q <= in_valid;
        end
    end

    // Payload is left unreset; it is only observed while valid_q is set.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            data_q <= in_data;
        end
    end

endmodule

// File: rtl/mul_cell_combiner.sv
// Sums the registered partial products of a 32x32 multiply in two valid/ready stages.
// Build option: MUL_CELL_HIGH_WORD_EN adds in_p4 and out_result_hi (product bits 63:32).
module mul_cell_combiner
    import mul_cell_pkg::*;
#(
    parameter int TAG_W = MUL_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PP_W-1:0]  in_p1,
    input  logic [PP_W-1:0]  in_p2,
    input  logic [PP_W-1:0]  in_p3,
`ifdef MUL_CELL_HIGH_WORD_EN
    input  logic [PP_W-1:0]  in_p4,
`endif
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PP_W-1:0]  out_result,
`ifdef MUL_CELL_HIGH_WORD_EN
    output logic [PP_W-1:0]  out_result_hi,
`endif
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

`ifdef MUL_CELL_HIGH_WORD_EN
    // The high word needs the whole p2+p3 sum, carry included.
    localparam int MID_W = PP_W + 1;
    localparam int S1_W  = 2 * PP_W + MID_W + TAG_W;
    localparam int S2_W  = 2 * PP_W + TAG_W;
`else
    localparam int MID_W = HALF_W;
    localparam int S1_W  = PP_W + MID_W + TAG_W;
    localparam int S2_W  = PP_W + TAG_W;
`endif

    logic             s1_valid;
    logic             s2_valid;
    logic             s2_free;
    logic [S1_W-1:0]  s1_d;
    logic [S1_W-1:0]  s1_q;
    logic [S2_W-1:0]  s2_d;
    logic [S2_W-1:0]  s2_q;
    logic [MID_W-1:0] mid_in;
    logic [PP_W-1:0]  s1_p1;
    logic [MID_W-1:0] s1_mid;
    logic [TAG_W-1:0] s1_tag;

`ifdef MUL_CELL_HIGH_WORD_EN
    logic [PP_W-1:0]   s1_p4;
    logic [2*PP_W-1:0] wide_sum;

    assign mid_in = {1'b0, in_p2} + {1'b0, in_p3};
    assign s1_d   = {in_p1, in_p4, mid_in, in_tag};
    assign {s1_p1, s1_p4, s1_mid, s1_tag} = s1_q;

    assign wide_sum = {{PP_W{1'b0}}, s1_p1}
                    + ({{(PP_W-1){1'b0}}, s1_mid} << HALF_W)
                    + {s1_p4, {PP_W{1'b0}}};
    assign s2_d = {wide_sum, s1_tag};
    assign {out_result_hi, out_result, out_tag} = s2_q;
`else
    // Upper halves of p2/p3 land at bit 32 and above, outside the low word.
    logic unused_hi_halves;
    assign unused_hi_halves = ^{in_p2[PP_W-1:HALF_W], in_p3[PP_W-1:HALF_W]};

    assign mid_in = in_p2[HALF_W-1:0] + in_p3[HALF_W-1:0];
    assign s1_d   = {in_p1, mid_in, in_tag};
    assign {s1_p1, s1_mid, s1_tag} = s1_q;

    assign s2_d = {s1_p1 + {s1_mid, {HALF_W{1'b0}}}, s1_tag};
    assign {out_result, out_tag} = s2_q;
`endif

    mul_pipe_stage #(.W(S1_W)) u_stage1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_d),
        .out_valid (s1_valid),
        .out_ready (s2_free),
        .out_data  (s1_q)
    );

    mul_pipe_stage #(.W(S2_W)) u_stage2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s1_valid),
        .in_ready  (s2_free),
        .in_data   (s2_d),
        .out_valid (s2_valid),
        .out_ready (out_ready),
        .out_data  (s2_q)
    );

    assign out_valid = s2_valid;
    assign busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_mul_cell_combiner.sv
// Bench for mul_cell_combiner: random operands checked against a*b mod 2^32 in order.
module tb_mul_cell_combiner;
    import mul_cell_pkg::*;

    localparam int TW = MUL_TAG_W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_p1 = '0;
    logic [31:0]   in_p2 = '0;
    logic [31:0]   in_p3 = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_result;
    logic [TW-1:0] out_tag;
    logic          busy;

    logic [31:0]   cur_a = '0;
    logic [31:0]   cur_b = '0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int in_cnt = 0;
    int out_cnt = 0;

    logic          last_in_fire = 1'b0;
    logic          prev_stall = 1'b0;
    logic [31:0]   prev_res = '0;
    logic [TW-1:0] prev_tag = '0;

    logic [$bits(mul_res_t)-1:0] exp_q[$];
    int fire_cyc[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mul_cell_combiner #(.TAG_W(TW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_p1      (in_p1),
        .in_p2      (in_p2),
        .in_p3      (in_p3),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_item(input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] tag);
        cur_a    = a;
        cur_b    = b;
        in_p1    = 32'(a[15:0]) * 32'(b[15:0]);
        in_p2    = 32'(a[15:0]) * 32'(b[31:16]);
        in_p3    = 32'(a[31:16]) * 32'(b[15:0]);
        in_tag   = tag;
        in_valid = 1'b1;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 9))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'(($urandom_range(0, 1) << 31) | $urandom_range(0, 65535));
            default: return $urandom;
        endcase
    endfunction

    task automatic drain();
        int n = 0;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain_idle", busy, 0);
        chk("drain_count", out_cnt, in_cnt);
    endtask

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        mul_res_t    exp_r;
        logic [63:0] prod;
        cyc++;
        if (reset) begin
            exp_q.delete();
            last_in_fire = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            // Occupancy is the number of accepted-but-not-delivered results.
            chk("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
            chk("busy", busy, exp_q.size() != 0);
            if (exp_q.size() == 2) chk("out_valid_full", out_valid, 1);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_result", out_result, prev_res);
                chk("stall_tag", out_tag, prev_tag);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", out_valid, 0);
                end else begin
                    exp_r = exp_q.pop_front();
                    chk("out_result", out_result, exp_r.result);
                    chk("out_tag", out_tag, exp_r.tag);
                    fire_cyc.push_back(cyc);
                    out_cnt++;
                end
            end
            last_in_fire = in_valid && in_ready;
            if (last_in_fire) begin
                prod         = {32'b0, cur_a} * {32'b0, cur_b};
                exp_r.result = prod[31:0];
                exp_r.tag    = in_tag;
                exp_q.push_back(exp_r);
                in_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = out_result;
            prev_tag   = out_tag;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int n;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);

        // Single transfer: exact latency and a hand-computed product.
        out_ready = 1'b1;
        @(posedge clk);
        #1 drive_item(32'h0001_0002, 32'h0003_0004, TW'(3));
        @(negedge clk);
        chk("t1_in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("t1_lat1_valid", out_valid, 0);
        @(negedge clk);
        chk("t1_valid", out_valid, 1);
        chk("t1_result", out_result, 32'h000A_0008);
        chk("t1_tag", out_tag, 3);

        // All-ones operands wrap to 1 in the low word.
        @(posedge clk);
        #1 drive_item(32'hFFFF_FFFF, 32'hFFFF_FFFF, TW'(31));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t2_valid", out_valid, 1);
        chk("t2_result", out_result, 32'h0000_0001);

        // Back-to-back: eight results on consecutive cycles.
        @(posedge clk);
        fire_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            #1 drive_item($urandom, $urandom, TW'(i));
            @(negedge clk);
            chk("b2b_in_ready", in_ready, 1);
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        drain();
        chk("b2b_count", fire_cyc.size(), 8);
        if (fire_cyc.size() == 8) chk("b2b_consecutive", fire_cyc[7] - fire_cyc[0], 7);

        // Output stalled with continuous input: only two entries fit.
        out_ready = 1'b0;
        base = in_cnt;
        @(posedge clk);
        #1 drive_item(rand_word(), rand_word(), TW'($urandom));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k >= 2) chk("stall_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            if (last_in_fire) drive_item(rand_word(), rand_word(), TW'($urandom));
        end
        in_valid = 1'b0;
        chk("stall_accepted", in_cnt - base, 2);
        drain();

        // Reset with both stages full discards everything.
        out_ready = 1'b0;
        @(posedge clk);
        #1 drive_item(rand_word(), rand_word(), TW'($urandom));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (last_in_fire) drive_item(rand_word(), rand_word(), TW'($urandom));
        end
        @(negedge clk);
        chk("full_busy", busy, 1);
        chk("full_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        base = out_cnt;
        repeat (5) @(negedge clk);
        chk("mid_rst_no_stale", out_cnt - base, 0);
        in_cnt  = 0;
        out_cnt = 0;

        // Random valid/ready traffic.
        base = in_cnt;
        n = 0;
        while (in_cnt - base < 10000 && n < 40000) begin
            @(posedge clk);
            #1;
            if (!in_valid || last_in_fire) begin
                if ($urandom_range(0, 3) != 0)
                    drive_item(rand_word(), rand_word(), TW'($urandom));
                else
                    in_valid = 1'b0;
            end
            if (n % 500 < 100) out_ready = ($urandom_range(0, 7) == 0);
            else               out_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        chk("rand_budget", (in_cnt - base) >= 10000, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
